// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between fetch (IF) and load/store (D).
// One transaction in flight; D has priority unless IF has waited STARVE_LIMIT cycles.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                owner,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [BE_W-1:0]     m_be_q, m_be_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;

  logic                idle;
  logic                grant_if;
  logic                grant_d;

  // Winner selection; grants only exist in IDLE
  always_comb begin
    idle     = (state_q == IDLE);
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (idle) begin
      grant_if = if_req && (!d_req || (starve_cnt_q >= CNT_MAX));
      grant_d  = d_req && !grant_if;
    end else begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
    end
  end

  // Next-state, latched request fields and starvation counter
  always_comb begin
    state_d      = state_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_be_d       = m_be_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d   = REQ;
          m_req_d   = 1'b1;
          owner_d   = 1'b1;
          m_we_d    = d_we;
          m_be_d    = d_be;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (grant_if) begin
          state_d   = REQ;
          m_req_d   = 1'b1;
          owner_d   = 1'b0;
          m_we_d    = 1'b0;
          m_be_d    = {BE_W{1'b1}};
          m_addr_d  = if_addr;
          m_wdata_d = {DATA_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (m_gnt) begin
          state_d = RSP;
          m_req_d = 1'b0;
        end else begin
          state_d = REQ;
        end
      end
      RSP: begin
        if (m_rvalid) begin
          state_d = IDLE;
        end else begin
          state_d = RSP;
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase

    // Saturates rather than wraps so a long wait can never look short again
    if (grant_if) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (if_req && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // State and request-field registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_be_q       <= {BE_W{1'b0}};
      m_addr_q     <= {ADDR_W{1'b0}};
      m_wdata_q    <= {DATA_W{1'b0}};
      owner_q      <= 1'b0;
      starve_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_be_q       <= m_be_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Handshake pulses are suppressed during reset so a dropped response never leaks out
  always_comb begin
    if_gnt    = !reset && grant_if;
    d_gnt     = !reset && grant_d;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if (!reset && (state_q == RSP) && m_rvalid) begin
      if_rvalid = !owner_q;
      d_rvalid  = owner_q;
    end else begin
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
    end
  end

  assign if_rdata = m_rdata;
  assign d_rdata  = m_rdata;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_be     = m_be_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign owner    = owner_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences for multi-cycle corners,
// and random stimulus compared every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int SL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_gnt, m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          owner, busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .owner(owner), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one outstanding transaction record plus an IF wait count
  bit            t_open;
  bit            t_accepted;
  bit            t_owner;
  bit            t_we;
  logic [BW-1:0] t_be;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  int            if_waited;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_if_gnt();
    return !reset && !t_open && if_req && (!d_req || if_waited >= SL);
  endfunction

  function automatic bit exp_d_gnt();
    return !reset && !t_open && d_req && !exp_if_gnt();
  endfunction

  task automatic check_model();
    bit resp;
    resp = !reset && t_open && t_accepted && m_rvalid;
    chk("m_if_gnt",    if_gnt,    exp_if_gnt());
    chk("m_d_gnt",     d_gnt,     exp_d_gnt());
    chk("m_if_rvalid", if_rvalid, resp && !t_owner);
    chk("m_d_rvalid",  d_rvalid,  resp && t_owner);
    chk("m_m_req",     m_req,     t_open && !t_accepted);
    chk("m_busy",      busy,      t_open);
    chk("m_owner",     owner,     t_owner);
    chk("m_m_we",      m_we,      t_we);
    chk("m_m_be",      m_be,      t_be);
    chk("m_m_addr",    m_addr,    t_addr);
    chk("m_m_wdata",   m_wdata,   t_wdata);
    chk("m_if_rdata",  if_rdata,  m_rdata);
    chk("m_d_rdata",   d_rdata,   m_rdata);
  endtask

  task automatic model_step();
    bit gi, gd;
    gi = exp_if_gnt();
    gd = exp_d_gnt();
    if (reset) begin
      t_open = 0; t_accepted = 0; t_owner = 0; t_we = 0;
      t_be = '0; t_addr = '0; t_wdata = '0; if_waited = 0;
    end else begin
      if (gi) if_waited = 0;
      else if (if_req) if_waited++;
      if (gi || gd) begin
        t_open = 1; t_accepted = 0; t_owner = gd;
        t_we    = gd ? d_we : 1'b0;
        t_be    = gd ? d_be : 4'hF;
        t_addr  = gd ? d_addr : if_addr;
        t_wdata = gd ? d_wdata : 32'h0;
      end else if (t_open && !t_accepted && m_gnt) begin
        t_accepted = 1;
      end else if (t_open && t_accepted && m_rvalid) begin
        t_open = 0; t_accepted = 0;
      end
    end
  endtask

  // Called at a negedge with inputs applied; returns at the following negedge
  task automatic cycle();
    #2;
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0;
    d_addr = '0; d_wdata = '0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  typedef struct {
    logic          rst, ir;
    logic [31:0]   ia;
    logic          dr, dw;
    logic [31:0]   da, dwd;
    logic [3:0]    dbe;
    logic          mg, mv;
    logic [31:0]   mrd;
    logic          eig, edg, emr;
    logic [31:0]   ema;
    logic          emwe;
    logic [3:0]    embe;
    logic          eir, edr, ebusy, eown;
  } vec_t;

  vec_t vec [14];
  bit   ig_log [10];
  bit   dg_log [10];

  initial begin
    vec[0]  = '{1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b0};
    vec[1]  = '{1'b0,1'b1,32'h10,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h0,1'b0,4'h0,1'b0,1'b0,1'b0,1'b0};
    vec[2]  = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h10,1'b0,4'hF,1'b0,1'b0,1'b1,1'b0};
    vec[3]  = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b1,32'hDEADBEEF, 1'b0,1'b0,1'b0,32'h10,1'b0,4'hF,1'b1,1'b0,1'b1,1'b0};
    vec[4]  = '{1'b0,1'b1,32'h20,1'b1,1'b1,32'h100,32'h55,4'h3,1'b0,1'b0,32'h0,    1'b0,1'b1,1'b0,32'h10,1'b0,4'hF,1'b0,1'b0,1'b0,1'b0};
    vec[5]  = '{1'b0,1'b1,32'h20,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1,1'b0,32'h0,       1'b0,1'b0,1'b1,32'h100,1'b1,4'h3,1'b0,1'b0,1'b1,1'b1};
    vec[6]  = '{1'b0,1'b1,32'h20,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b1,32'h1234,    1'b0,1'b0,1'b0,32'h100,1'b1,4'h3,1'b0,1'b1,1'b1,1'b1};
    vec[7]  = '{1'b0,1'b1,32'h20,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,32'h100,1'b1,4'h3,1'b0,1'b0,1'b0,1'b1};
    vec[8]  = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b1,32'h0,        1'b0,1'b0,1'b1,32'h20,1'b0,4'hF,1'b0,1'b0,1'b1,1'b0};
    vec[9]  = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b1,1'b1,32'h0,        1'b0,1'b0,1'b1,32'h20,1'b0,4'hF,1'b0,1'b0,1'b1,1'b0};
    vec[10] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h20,1'b0,4'hF,1'b0,1'b0,1'b1,1'b0};
    vec[11] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b1,32'hCAFEF00D, 1'b0,1'b0,1'b0,32'h20,1'b0,4'hF,1'b1,1'b0,1'b1,1'b0};
    vec[12] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b1,32'h0,        1'b0,1'b0,1'b0,32'h20,1'b0,4'hF,1'b0,1'b0,1'b0,1'b0};
    vec[13] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h20,1'b0,4'hF,1'b0,1'b0,1'b0,1'b0};

    t_open = 0; t_accepted = 0; t_owner = 0; t_we = 0;
    t_be = '0; t_addr = '0; t_wdata = '0; if_waited = 0;
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      reset = vec[i].rst; if_req = vec[i].ir; if_addr = vec[i].ia;
      d_req = vec[i].dr; d_we = vec[i].dw; d_addr = vec[i].da; d_wdata = vec[i].dwd; d_be = vec[i].dbe;
      m_gnt = vec[i].mg; m_rvalid = vec[i].mv; m_rdata = vec[i].mrd;
      #1;
      chk($sformatf("v%0d_if_gnt", i),    if_gnt,    vec[i].eig);
      chk($sformatf("v%0d_d_gnt", i),     d_gnt,     vec[i].edg);
      chk($sformatf("v%0d_m_req", i),     m_req,     vec[i].emr);
      chk($sformatf("v%0d_m_addr", i),    m_addr,    vec[i].ema);
      chk($sformatf("v%0d_m_we", i),      m_we,      vec[i].emwe);
      chk($sformatf("v%0d_m_be", i),      m_be,      vec[i].embe);
      chk($sformatf("v%0d_if_rvalid", i), if_rvalid, vec[i].eir);
      chk($sformatf("v%0d_d_rvalid", i),  d_rvalid,  vec[i].edr);
      chk($sformatf("v%0d_busy", i),      busy,      vec[i].ebusy);
      chk($sformatf("v%0d_owner", i),     owner,     vec[i].eown);
      chk($sformatf("v%0d_if_rdata", i),  if_rdata,  vec[i].mrd);
      cycle();
    end

    // Starvation: D streams continuously with a one-cycle memory
    idle_inputs();
    if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h300; d_be = 4'h1;
    m_gnt = 1; m_rvalid = 1; m_rdata = 32'h77;
    for (int k = 0; k < 10; k++) begin
      #1;
      ig_log[k] = if_gnt;
      dg_log[k] = d_gnt;
      cycle();
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("starve_if_gnt%0d", k), 32'(ig_log[k]), 32'(k == 6));
      chk($sformatf("starve_d_gnt%0d", k),  32'(dg_log[k]), 32'(k == 0 || k == 3 || k == 9));
    end
    if_req = 0; d_req = 0;
    repeat (3) cycle();

    // Memory stall with both requesters waiting
    idle_inputs();
    d_req = 1; d_addr = 32'hABC0; d_wdata = 32'h99; d_be = 4'hC; d_we = 1;
    cycle();
    if_req = 1; if_addr = 32'h44; d_addr = 32'h1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_m_req", m_req, 1'b1);
      chk("stall_m_addr", m_addr, 32'hABC0);
      chk("stall_gnt", {if_gnt, d_gnt}, 2'b00);
      chk("stall_busy", busy, 1'b1);
      cycle();
    end
    if_req = 0; d_req = 0; m_gnt = 1;
    cycle();
    m_gnt = 0; m_rvalid = 1;
    #1;
    chk("stall_d_rvalid", d_rvalid, 1'b1);
    cycle();
    m_rvalid = 0;
    cycle();

    // Reset while a D transaction waits for its response
    d_req = 1; d_we = 0; d_addr = 32'h200;
    cycle();
    d_req = 0; m_gnt = 1;
    cycle();
    m_gnt = 0;
    #1;
    chk("rst_pre_owner", owner, 1'b1);
    chk("rst_pre_busy", busy, 1'b1);
    cycle();
    reset = 1;
    cycle();
    reset = 0; m_rvalid = 1; m_rdata = 32'hBAD0BAD0;
    #1;
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_if_rvalid", if_rvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_req", m_req, 1'b0);
    cycle();
    m_rvalid = 0;
    cycle();

    // Random stimulus against the model
    for (int k = 0; k < 800; k++) begin
      reset    = ($urandom_range(0, 99) == 0);
      if_req   = $urandom_range(0, 2) != 0;
      if_addr  = $urandom;
      d_req    = $urandom_range(0, 2) != 0;
      d_we     = $urandom_range(0, 1);
      d_be     = $urandom;
      d_addr   = $urandom;
      d_wdata  = $urandom;
      m_gnt    = $urandom_range(0, 1);
      m_rvalid = $urandom_range(0, 1);
      m_rdata  = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the core's single unified memory port between instruction fetch (IF) and load/store (D). Each requester uses a req/gnt/rvalid handshake. One transaction is in flight at a time, and the downstream request is driven from registered fields. Priority is fixed (D over IF), with a starvation guard so a busy load/store stream cannot stall fetch indefinitely. Sits between ProgramCounter/InstructionMemory-side fetch logic, the load/store unit and the shared memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)
- STARVE_LIMIT, 4, consecutive IF-waiting cycles after which IF wins the next arbitration
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse; fetch request accepted
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  load/store request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse; D request accepted
- d_rvalid  out  1  one-cycle pulse; load data valid / store ack
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory request, registered
- m_we, m_be, m_addr, m_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered request fields
- m_gnt  in  1  memory accepted m_req this cycle
- m_rvalid  in  1  memory response (reads and writes both return one)
- m_rdata  in  DATA_W  memory read data
- owner  out  1  0 = IF, 1 = D; owner of in-flight transaction
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, RSP.
- IDLE: if any req is high, pick a winner, then:
  - pulse that requester's gnt this cycle (combinational from req and state);
  - latch addr/we/be/wdata into the m_* registers (IF: we=0, be=all ones, wdata=0);
  - set owner, go to REQ.
- Winner selection in IDLE:
  - only one req → that one;
  - both req → D, unless starve_cnt >= STARVE_LIMIT, then IF.
- REQ: m_req=1 with latched fields held stable. On m_gnt → RSP.
- RSP: m_req=0. On m_rvalid: pulse if_rvalid or d_rvalid per owner (combinational from m_rvalid) → IDLE.
- rdata routing: if_rdata and d_rdata both equal m_rdata combinationally; only the rvalid pulses are gated.
- m_rvalid arriving in IDLE or REQ is ignored; no rvalid pulse is produced.
- starve_cnt:
  - saturating counter, width $clog2(STARVE_LIMIT+1);
  - increments each cycle if_req=1 and if_gnt=0;
  - clears to 0 on if_gnt or reset;
  - does not wrap.
- Requesters may drop req the cycle after gnt. A req dropped before gnt is withdrawn without side effects.
- No new grant is issued outside IDLE. Requests raised while busy wait.

## Timing
- Reset: state=IDLE, m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0, owner=0, starve_cnt=0. gnt/rvalid outputs are 0 (busy=0).
- Reset mid-transaction: return to IDLE next edge. The outstanding memory response is dropped and never forwarded.
- Cycle 0: req seen in IDLE, gnt pulses.
- Cycle 1: m_req=1.
- m_gnt in cycle N → RSP from N+1.
- m_rvalid in cycle M ≥ N+1 → rvalid pulse in M, IDLE in M+1.
- Minimum transaction: gnt at T, m_gnt at T+1, m_rvalid at T+2. Next grant earliest at T+3.
- m_gnt and m_rvalid in the same REQ cycle: m_rvalid is ignored. The memory must respond strictly after grant.

## Test plan
- Single fetch: if_req=1, if_addr=0x10 at T; m_gnt at T+1; m_rvalid at T+2 with m_rdata=0xDEADBEEF → if_gnt@T, m_req@T+1 with m_addr=0x10, m_we=0, m_be=0xF; if_rvalid@T+2, if_rdata=0xDEADBEEF; d_rvalid=0.
- Simultaneous requests, starve_cnt=0: if_req=d_req=1, d_we=1, d_addr=0x100, d_wdata=0x55, d_be=0x3 → d_gnt first; m_we=1, m_be=0x3; IF granted at the IDLE after d_rvalid.
- Starvation: d_req held high continuously with 1-cycle memory → after starve_cnt reaches 4, the next IDLE grants IF despite d_req=1; starve_cnt then reads 0.
- Memory stall: m_gnt low for 5 cycles → m_req and m_addr stable throughout; no further gnt pulses; busy=1.
- Reset in RSP with owner=D, then m_rvalid=1 the cycle after reset → no d_rvalid; state IDLE, m_req=0, busy=0.
- Stray response: m_rvalid=1 while IDLE → no rvalid output; state remains IDLE.
